// File: rtl/median_feeder_if.sv
`default_nettype none
// clk_rstn_if: bundles the single rising-edge clock and the asynchronous active-low reset.
// Revision 1.0
interface clk_rstn_if;
    logic clk_i;
    logic rstn_i;

    modport dut (input clk_i, input rstn_i);
endinterface
`default_nettype wire

// File: rtl/median_feeder.sv
`default_nettype none
// median_feeder: buffers producer samples and presents them one at a time to the median filter.
// Revision 1.0
module median_feeder #(
    parameter int DEPTH  = 8,
    parameter int GAP_W  = 8,
    parameter int ACK_TO = 4
) (
    clk_rstn_if.dut                 interf,
    input  logic                    wr_en_i,
    input  logic [15:0]             wr_data_i,
    input  logic                    enable_i,
    input  logic [GAP_W-1:0]        gap_i,
    input  logic                    ack_i,
    output logic [15:0]             data_o,
    output logic                    data_av_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic                    overflow_o
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_tw = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = interf.clk_i;
    assign rst_n = interf.rstn_i;

    logic [15:0]       mem_q [DEPTH];
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [c_tw-1:0]   wait_q, wait_d;
    logic [15:0]       data_q, data_d;
    logic              data_av_q, data_av_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              w_pop;
    logic              w_push;

    // The pop is tied to the IDLE->SEND edge; a full FIFO may accept a write on that same edge.
    assign w_pop  = (state_q == IDLE) && enable_i && !empty_q;
    assign w_push = wr_en_i && (!full_q || w_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en_i && full_q && !w_pop) begin
            overflow_d = 1'b1;
        end
        full_d  = (count_d == c_cw'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        wait_d    = wait_q;
        data_d    = data_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_pop) begin
                    state_d = SEND;
                    data_d  = mem_q[rd_ptr_q];
                end
            end
            SEND: begin
                state_d = WAIT_ACK;
                wait_d  = '0;
            end
            WAIT_ACK: begin
                // An ack on the final allowed cycle still counts as a normal acknowledge.
                if (ack_i || (wait_q == c_tw'(ACK_TO - 1))) begin
                    timeout_d = !ack_i;
                    if (gap_i != '0) begin
                        state_d = GAP;
                        gap_d   = gap_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        data_av_d = (state_d == SEND);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            gap_q      <= '0;
            wait_q     <= '0;
            data_q     <= '0;
            data_av_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            wait_q     <= wait_d;
            data_q     <= data_d;
            data_av_q  <= data_av_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign data_o     = data_q;
    assign data_av_o  = data_av_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_median_feeder.sv
`default_nettype none
// tb_median_feeder: directed stimulus with a timeline-based reference model and per-cycle compare.
// Revision 1.0
module tb_median_feeder;
    localparam int DEPTH  = 8;
    localparam int ACK_TO = 4;
    localparam int BIG    = 1 << 30;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        en = 1'b0;
    logic [7:0]  gap = '0;
    logic        ack_i;
    logic        ack_echo;
    logic        ack_auto = 1'b1;
    logic [15:0] data_o;
    logic        data_av_o, full_o, empty_o, busy_o, timeout_o, overflow_o;
    logic [3:0]  count_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    clk_rstn_if u_if();
    assign u_if.clk_i  = clk;
    assign u_if.rstn_i = rstn;

    median_feeder #(.DEPTH(DEPTH), .GAP_W(8), .ACK_TO(ACK_TO)) dut (
        .interf     (u_if),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .enable_i   (en),
        .gap_i      (gap),
        .ack_i      (ack_i),
        .data_o     (data_o),
        .data_av_o  (data_av_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Filter stand-in: its registered control_o echoes data_av_sync one cycle later.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ack_echo <= 1'b0;
        else       ack_echo <= data_av_o;
    end
    assign ack_i = ack_auto ? ack_echo : 1'b0;

    // Reference model: a sample queue plus the cycle numbers at which events happen.
    logic [15:0] mq[$];
    logic [15:0] m_data;
    int          m_send_cyc, m_to_cyc, m_free_at;
    bit          m_waiting, m_ov, m_pop;
    int          prev;

    task automatic model_reset();
        mq.delete();
        m_data     = '0;
        m_send_cyc = -100;
        m_to_cyc   = -100;
        m_free_at  = 0;
        m_waiting  = 1'b0;
        m_ov       = 1'b0;
    endtask

    initial forever begin
        @(negedge rstn);
        model_reset();
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rstn === 1'b1) begin
            prev  = cyc - 1;
            m_pop = (m_free_at <= prev) && en && (mq.size() > 0);
            if (m_waiting && prev > m_send_cyc) begin
                if (ack_i) begin
                    m_waiting = 1'b0;
                    m_free_at = cyc + int'(gap);
                end else if (prev - m_send_cyc == ACK_TO) begin
                    m_waiting = 1'b0;
                    m_to_cyc  = cyc;
                    m_free_at = cyc + int'(gap);
                end
            end
            if (m_pop) begin
                m_data     = mq.pop_front();
                m_send_cyc = cyc;
                m_waiting  = 1'b1;
                m_free_at  = BIG;
            end
            if (wr_en) begin
                if (mq.size() < DEPTH) mq.push_back(wr_data);
                else                   m_ov = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("data_av", 32'(data_av_o), 32'(cyc == m_send_cyc));
            chk("data",    32'(data_o),    32'(m_data));
            chk("busy",    32'(busy_o),    32'(cyc < m_free_at));
            chk("timeout", 32'(timeout_o), 32'(cyc == m_to_cyc));
            chk("count",   32'(count_o),   32'(mq.size()));
            chk("full",    32'(full_o),    32'(mq.size() == DEPTH));
            chk("empty",   32'(empty_o),   32'(mq.size() == 0));
            chk("ovf",     32'(overflow_o), 32'(m_ov));
        end
    end

    int          s_cyc[$];
    logic [15:0] s_dat[$];
    int          t_cyc[$];

    initial forever begin
        @(negedge clk);
        if (rstn === 1'b1 && data_av_o === 1'b1) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(data_o);
        end
        if (rstn === 1'b1 && timeout_o === 1'b1) t_cyc.push_back(cyc);
    end

    task automatic clear_logs();
        s_cyc.delete();
        s_dat.delete();
        t_cyc.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rstn = 1'b0;
        step(3);
        rstn   = 1'b1;
        chk_on = 1'b1;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);

        // Single sample
        en = 1'b1;
        gap = 8'd0;
        wr(16'h1234);
        chk("single_empty", 32'(empty_o), 32'd0);
        chk("single_noav",  32'(data_av_o), 32'd0);
        step(1);
        chk("single_av",   32'(data_av_o), 32'd1);
        chk("single_data", 32'(data_o), 32'h1234);
        step(2);
        chk("single_idle", 32'(busy_o), 32'd0);

        // Burst pacing with gap 2
        @(negedge clk);
        gap = 8'd2;
        clear_logs();
        wr_en = 1'b1; wr_data = 16'h0005;
        @(negedge clk); wr_data = 16'h0003;
        @(negedge clk); wr_data = 16'h0009;
        @(negedge clk); wr_en = 1'b0;
        step(25);
        chk("burst_n", 32'(s_dat.size()), 32'd3);
        if (s_dat.size() == 3) begin
            chk("burst_d0", 32'(s_dat[0]), 32'h5);
            chk("burst_d1", 32'(s_dat[1]), 32'h3);
            chk("burst_d2", 32'(s_dat[2]), 32'h9);
            chk("burst_sp1", 32'(s_cyc[1] - s_cyc[0]), 32'd5);
            chk("burst_sp2", 32'(s_cyc[2] - s_cyc[1]), 32'd5);
        end

        // Timeout without ack, then recovery
        @(negedge clk);
        gap = 8'd0;
        ack_auto = 1'b0;
        clear_logs();
        wr(16'hBEEF);
        step(12);
        ack_auto = 1'b1;
        wr(16'h0042);
        step(6);
        chk("to_n",  32'(t_cyc.size()), 32'd1);
        chk("to_sn", 32'(s_dat.size()), 32'd2);
        if (t_cyc.size() == 1 && s_dat.size() == 2) begin
            chk("to_delay", 32'(t_cyc[0] - s_cyc[0]), 32'd5);
            chk("to_next",  32'(s_dat[1]), 32'h0042);
        end

        // Simultaneous push and pop while full
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 16'h0010 + 16'(i);
            @(negedge clk);
        end
        chk("pp_count0", 32'(count_o), 32'd8);
        chk("pp_full0",  32'(full_o), 32'd1);
        clear_logs();
        en = 1'b1; wr_data = 16'hAAAA;
        @(negedge clk);
        wr_en = 1'b0;
        chk("pp_count", 32'(count_o), 32'd8);
        chk("pp_ovf",   32'(overflow_o), 32'd0);
        chk("pp_data",  32'(data_o), 32'h0010);
        step(40);
        chk("pp_n", 32'(s_dat.size()), 32'd9);
        if (s_dat.size() == 9) chk("pp_last", 32'(s_dat[8]), 32'hAAAA);

        // Full and overflow
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 16'h0020 + 16'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("ov_full",  32'(full_o), 32'd1);
        chk("ov_count", 32'(count_o), 32'd8);
        chk("ov_flag",  32'(overflow_o), 32'd1);
        clear_logs();
        en = 1'b1;
        step(40);
        chk("ov_n", 32'(s_dat.size()), 32'd8);
        if (s_dat.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("ov_val", 32'(s_dat[i]), 32'h20 + 32'(i));
        end

        // Reset in the 4th GAP cycle
        gap = 8'd10;
        clear_logs();
        @(negedge clk); wr_en = 1'b1; wr_data = 16'h7777;
        @(negedge clk); wr_data = 16'h8888;
        @(negedge clk); wr_en = 1'b0;
        chk("mg_av", 32'(data_av_o), 32'd1);
        step(5);
        chk("mg_busy", 32'(busy_o), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mg_rdata",  32'(data_o), 32'd0);
        chk("mg_rav",    32'(data_av_o), 32'd0);
        chk("mg_rbusy",  32'(busy_o), 32'd0);
        chk("mg_rto",    32'(timeout_o), 32'd0);
        chk("mg_rovf",   32'(overflow_o), 32'd0);
        chk("mg_rcount", 32'(count_o), 32'd0);
        chk("mg_rempty", 32'(empty_o), 32'd1);
        chk("mg_rfull",  32'(full_o), 32'd0);
        step(2);
        rstn = 1'b1;
        clear_logs();
        step(20);
        chk("mg_empty", 32'(empty_o), 32'd1);
        chk("mg_noav",  32'(s_dat.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
